bcd_result_display: RTL and testbench

- Downstream stage of the single-digit BCD adder/subtractor: captures its result and drives a 4-digit, common-anode, time-multiplexed 7-segment display.
- Inputs captured on a load strobe: BCD digit, carry, sign flag.
- Scan: a refresh counter steps one anode per slot. Registered decoder produces the segment pattern for the active digit.
- Sits between the arithmetic block and the board display pins.

---
 rtl/bcd_result_display.sv | 124 ++++++++++++
 tb/tb_bcd_result_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_result_display.sv
`default_nettype none
// ============================================================================
// Module   : bcd_result_display
// Brief    : Latches the BCD adder/subtractor result and scans it onto a
//            4-digit common-anode 7-segment display. Optional build macro:
//            LEADING_ZERO_BLANK_EN (blank tens digit, sign shifts into it).
// Revision : 1.0  initial release
// ============================================================================
module bcd_result_display #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] decimal_place,
  input  logic       carry,
  input  logic       neg1pos0,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       loaded
);

  localparam int unsigned c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(REFRESH_DIV - 1);

  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] c_SEG_DASH  = 7'b0111111;
  localparam logic [6:0] c_SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] c_SEG_ONE   = 7'b1111001;

  logic [3:0]         r_dig;
  logic               r_cy;
  logic               r_neg;
  logic               r_loaded;
  logic [c_CNT_W-1:0] r_cnt;
  logic [1:0]         r_sel;
  logic [6:0]         r_seg;
  logic [3:0]         r_an;

  logic               w_wrap;
  logic [6:0]         w_seg_nxt;
  logic [3:0]         w_an_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0000110;  // invalid BCD shows 'E'
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dig    <= 4'd0;
      r_cy     <= 1'b0;
      r_neg    <= 1'b0;
      r_loaded <= 1'b0;
    end else if (load) begin
      r_dig    <= decimal_place;
      r_cy     <= carry;
      r_neg    <= neg1pos0;
      r_loaded <= 1'b1;
    end
  end

  assign w_wrap = (r_cnt == c_CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  always_comb begin
    w_seg_nxt = c_SEG_BLANK;
    w_an_nxt  = ~(4'b0001 << r_sel);
    case (r_sel)
      2'd0: w_seg_nxt = f_decode(r_dig);
`ifdef LEADING_ZERO_BLANK_EN
      // A lone negative result pulls its sign right next to the units digit.
      2'd1: w_seg_nxt = r_cy ? c_SEG_ONE : (r_neg ? c_SEG_DASH : c_SEG_BLANK);
      2'd2: w_seg_nxt = (r_cy && r_neg) ? c_SEG_DASH : c_SEG_BLANK;
`else
      2'd1: w_seg_nxt = r_cy ? c_SEG_ONE : c_SEG_ZERO;
      2'd2: w_seg_nxt = r_neg ? c_SEG_DASH : c_SEG_BLANK;
`endif
      default: w_seg_nxt = c_SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= c_SEG_BLANK;
      r_an  <= 4'b1111;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
    end
  end

  assign seg    = r_seg;
  assign an     = r_an;
  assign dp     = 1'b1;
  assign loaded = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_bcd_result_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_result_display
// Brief    : Self-checking bench: per-cycle scoreboard of expected pins plus a
//            table of load vectors checked slot by slot.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_result_display;

  localparam int unsigned DIV = 4;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] decimal_place = 4'd0;
  logic       carry = 1'b0;
  logic       neg1pos0 = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       loaded;

  bcd_result_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .decimal_place(decimal_place),
    .carry(carry), .neg1pos0(neg1pos0), .seg(seg), .an(an), .dp(dp),
    .loaded(loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ld;
  } exp_t;

  typedef struct {
    logic [3:0] dig;
    logic       cy;
    logic       neg;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int n_chk = 0;
  int n_fail = 0;

  // reference state: counter phase and captured operands
  int         m_cnt = 0;
  int         m_sel = 0;
  logic [3:0] m_dig = 4'd0;
  logic       m_cy = 1'b0;
  logic       m_neg = 1'b0;
  logic       m_loaded = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
            7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110};
    return tbl[d];
  endfunction

  function automatic logic [6:0] slot_seg(input int sel);
    case (sel)
      0: return digit_seg(m_dig);
`ifdef LEADING_ZERO_BLANK_EN
      1: return m_cy ? 7'b1111001 : (m_neg ? DASH : BLANK);
      2: return (m_cy && m_neg) ? DASH : BLANK;
`else
      1: return m_cy ? 7'b1111001 : 7'b1000000;
      2: return m_neg ? DASH : BLANK;
`endif
      default: return BLANK;
    endcase
  endfunction

  function automatic logic [3:0] slot_an(input int sel);
    case (sel)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  // Drive one cycle: push the expectation for the coming edge, advance the
  // model, then compare after the edge.
  task automatic tick(input logic ld, input logic [3:0] d, input logic c, input logic n);
    exp_t e;
    load = ld; decimal_place = d; carry = c; neg1pos0 = n;
    e.seg = slot_seg(m_sel);
    e.an  = slot_an(m_sel);
    e.ld  = m_loaded | ld;
    sb.push_back(e);
    if (ld) begin
      m_dig = d; m_cy = c; m_neg = n; m_loaded = 1'b1;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_sel = (m_sel + 1) % 4;
    end else begin
      m_cnt++;
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("seg", 32'(seg), 32'(e.seg));
      chk("an", 32'(an), 32'(e.an));
      chk("loaded", 32'(loaded), 32'(e.ld));
      chk("dp", 32'(dp), 32'd1);
    end
  endtask

  task automatic idle();
    tick(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sel = 0; m_dig = 4'd0; m_cy = 1'b0; m_neg = 1'b0; m_loaded = 1'b0;
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{4'd5,  1'b1, 1'b0, 7'b0010010, 7'b1111001, BLANK};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{4'd3,  1'b0, 1'b1, 7'b0110000, DASH,       BLANK};
    vecs[3] = '{4'd9,  1'b0, 1'b0, 7'b0010000, BLANK,      BLANK};
`else
    vecs[1] = '{4'd3,  1'b0, 1'b1, 7'b0110000, 7'b1000000, DASH};
    vecs[3] = '{4'd9,  1'b0, 1'b0, 7'b0010000, 7'b1000000, BLANK};
`endif
    vecs[2] = '{4'd12, 1'b1, 1'b1, 7'b0000110, 7'b1111001, DASH};
    vecs[4] = '{4'd0,  1'b1, 1'b1, 7'b1000000, 7'b1111001, DASH};

    // Held in reset across clock edges: everything blank.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg), 32'(BLANK));
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_loaded", 32'(loaded), 32'd0);
    rst = 1'b0;
    model_reset();

    // One full idle scan: 0, 0 (or blank tens), blank, blank.
    for (int i = 0; i < 16; i++) idle();

    // Table vectors: load, then check each slot's pattern for a whole scan.
    for (int v = 0; v < 5; v++) begin
      tick(1'b1, vecs[v].dig, vecs[v].cy, vecs[v].neg);
      for (int i = 0; i < 16; i++) begin
        idle();
        case (an)
          4'b1110: chk("tbl_units", 32'(seg), 32'(vecs[v].s0));
          4'b1101: chk("tbl_slot1", 32'(seg), 32'(vecs[v].s1));
          4'b1011: chk("tbl_slot2", 32'(seg), 32'(vecs[v].s2));
          4'b0111: chk("tbl_slot3", 32'(seg), 32'(BLANK));
          default: chk("tbl_an_onehot", 32'(an), 32'hE);
        endcase
      end
    end

    // Load while units slot active and stays active for two more edges.
    while (!(m_sel == 0 && m_cnt == 0)) idle();
    tick(1'b1, 4'd7, 1'b0, 1'b0);
    chk("lat_seg_old", 32'(seg), 32'(7'b1000000));
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    chk("lat_seg_new", 32'(seg), 32'(7'b1111000));
    chk("lat_an", 32'(an), 32'hE);

    // Back-to-back loads: the last one wins.
    tick(1'b1, 4'd1, 1'b1, 1'b0);
    tick(1'b1, 4'd2, 1'b0, 1'b1);
    tick(1'b1, 4'd8, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) idle();

    // Load on the edge that wraps the counter.
    while (m_cnt != DIV - 1) idle();
    tick(1'b1, 4'd6, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) idle();

    // Random loads at random phases.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0)
        tick(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        idle();
    end

    // Asynchronous reset in the middle of a slot.
    while (!(m_sel == 1 && m_cnt == 2)) idle();
    tick(1'b1, 4'd9, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("amid_seg", 32'(seg), 32'(BLANK));
    chk("amid_an", 32'(an), 32'hF);
    chk("amid_loaded", 32'(loaded), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    // Cleared captures and scan restarted at slot 0.
    for (int i = 0; i < 16; i++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
